pipelined_add_sub: RTL and testbench

//   Parametrised, pipelined WIDTH-bit adder/subtractor, successor to the 1-bit full adder.

---
 rtl/pipelined_add_sub_if.sv | 25 ++
 rtl/pipelined_add_sub.sv | 89 ++++++++
 tb/tb_pipelined_add_sub.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/pipelined_add_sub_if.sv
// Operation/result bundle for the pipelined adder/subtractor.
// The master side issues operations and the slave side (the pipeline) returns results.
interface pipelined_add_sub_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output in_valid, sub, a, b, cin,
      input  out_valid, sum, cout, ovf
   );

   modport slave (
      input  in_valid, sub, a, b, cin,
      output out_valid, sum, cout, ovf
   );
endinterface

// File: rtl/pipelined_add_sub.sv
// Pipelined WIDTH-bit adder/subtractor: one CW-bit chunk is summed per stage and the chunk carry
// is registered, so latency is STAGES enabled cycles at a throughput of one operation per cycle.
module pipelined_add_sub #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input logic               clk,
   input logic               rst,
   input logic               ce,
   pipelined_add_sub_if.slave bus
);
   localparam int CW = WIDTH / STAGES;

   function automatic logic [CW:0] add_chunk(input logic [CW-1:0] x,
                                             input logic [CW-1:0] y,
                                             input logic          c);
      return {1'b0, x} + {1'b0, y} + {{CW{1'b0}}, c};
   endfunction

   logic             vld_p [STAGES];
   logic [WIDTH-1:0] opa_p [STAGES];
   logic [WIDTH-1:0] opb_p [STAGES];
   logic [WIDTH-1:0] res_p [STAGES];
   logic             cy_p  [STAGES];
   logic             ovf_p;

   logic             stg_vld [STAGES];
   logic [WIDTH-1:0] stg_a   [STAGES];
   logic [WIDTH-1:0] stg_b   [STAGES];
   logic [WIDTH-1:0] stg_res [STAGES];
   logic             stg_cy  [STAGES];
   logic [CW:0]      stg_sum [STAGES];
   logic [WIDTH-1:0] stg_nxt [STAGES];
   logic             msb_cin;

   for (genvar k = 0; k < STAGES; k++) begin : g_stg
      if (k == 0) begin : g_in
         // Subtraction becomes a + ~b + 1: invert b once here and force the first carry.
         assign stg_vld[k] = bus.in_valid;
         assign stg_a[k]   = bus.a;
         assign stg_b[k]   = bus.sub ? ~bus.b : bus.b;
         assign stg_cy[k]  = bus.sub | bus.cin;
         assign stg_res[k] = '0;
      end else begin : g_chain
         assign stg_vld[k] = vld_p[k-1];
         assign stg_a[k]   = opa_p[k-1];
         assign stg_b[k]   = opb_p[k-1];
         assign stg_cy[k]  = cy_p[k-1];
         assign stg_res[k] = res_p[k-1];
      end

      assign stg_sum[k] = add_chunk(stg_a[k][k*CW +: CW], stg_b[k][k*CW +: CW], stg_cy[k]);
      assign stg_nxt[k] = (stg_res[k] & ~(WIDTH'({CW{1'b1}}) << (k*CW)))
                        | (WIDTH'(stg_sum[k][CW-1:0]) << (k*CW));
   end

   // Carry into the MSB is recovered from the MSB sum bit and its two operand bits.
   assign msb_cin = stg_a[STAGES-1][WIDTH-1] ^ stg_b[STAGES-1][WIDTH-1]
                  ^ stg_nxt[STAGES-1][WIDTH-1];

   // ---- stage registers _p0 .. _p(STAGES-1); the last stage is the output register ----
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < STAGES; k++) begin
            vld_p[k] <= 1'b0;
            opa_p[k] <= '0;
            opb_p[k] <= '0;
            res_p[k] <= '0;
            cy_p[k]  <= 1'b0;
         end
         ovf_p <= 1'b0;
      end else if (ce) begin
         for (int k = 0; k < STAGES; k++) begin
            vld_p[k] <= stg_vld[k];
            opa_p[k] <= stg_a[k];
            opb_p[k] <= stg_b[k];
            res_p[k] <= stg_nxt[k];
            cy_p[k]  <= stg_sum[k][CW];
         end
         ovf_p <= msb_cin ^ stg_sum[STAGES-1][CW];
      end
   end

   // ---- outputs come straight from the final stage registers ----
   assign bus.out_valid = vld_p[STAGES-1];
   assign bus.sum       = res_p[STAGES-1];
   assign bus.cout      = cy_p[STAGES-1];
   assign bus.ovf       = ovf_p;
endmodule

// File: tb/tb_pipelined_add_sub.sv
// Drives identical operations into 16-bit adders of depth 1, 4 and 16 and compares every
// cycle against a history of results computed with plain integer arithmetic.
module tb_pipelined_add_sub;
   localparam int N = 2048;

   logic clk, rst, ce;
   logic in_valid, sub, cin;
   logic [15:0] a, b;

   pipelined_add_sub_if #(.WIDTH(16)) bus1 ();
   pipelined_add_sub_if #(.WIDTH(16)) bus4 ();
   pipelined_add_sub_if #(.WIDTH(16)) bus16 ();

   assign bus1.in_valid  = in_valid;  assign bus1.sub  = sub;  assign bus1.cin  = cin;
   assign bus1.a         = a;         assign bus1.b    = b;
   assign bus4.in_valid  = in_valid;  assign bus4.sub  = sub;  assign bus4.cin  = cin;
   assign bus4.a         = a;         assign bus4.b    = b;
   assign bus16.in_valid = in_valid;  assign bus16.sub = sub;  assign bus16.cin = cin;
   assign bus16.a        = a;         assign bus16.b   = b;

   pipelined_add_sub #(.WIDTH(16), .STAGES(1))  dut1  (.clk(clk), .rst(rst), .ce(ce), .bus(bus1));
   pipelined_add_sub #(.WIDTH(16), .STAGES(4))  dut4  (.clk(clk), .rst(rst), .ce(ce), .bus(bus4));
   pipelined_add_sub #(.WIDTH(16), .STAGES(16)) dut16 (.clk(clk), .rst(rst), .ce(ce), .bus(bus16));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   int ecyc   = 0;
   bit held   = 1'b0;

   logic        h_vld  [N];
   logic [15:0] h_sum  [N];
   logic        h_cout [N];
   logic        h_ovf  [N];

   logic [15:0] prv_sum  [3];
   logic        prv_vld  [3];
   logic        prv_cout [3];
   logic        prv_ovf  [3];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic check_out(input int d, input int lat, input logic ov, input logic [15:0] s,
                            input logic co, input logic of);
      int   idx;
      logic ev;
      idx = ecyc - lat;
      ev  = (idx >= 0) ? h_vld[idx % N] : 1'b0;
      chk($sformatf("L%0d_vld", lat), {31'b0, ov}, {31'b0, ev});
      chk($sformatf("L%0d_x", lat), {31'b0, $isunknown({ov, s, co, of})}, 32'd0);
      if (ev) begin
         chk($sformatf("L%0d_sum", lat), {16'b0, s}, {16'b0, h_sum[idx % N]});
         chk($sformatf("L%0d_cout", lat), {31'b0, co}, {31'b0, h_cout[idx % N]});
         chk($sformatf("L%0d_ovf", lat), {31'b0, of}, {31'b0, h_ovf[idx % N]});
      end
      if (held) begin
         chk($sformatf("L%0d_frz_vld", lat), {31'b0, ov}, {31'b0, prv_vld[d]});
         chk($sformatf("L%0d_frz_sum", lat), {16'b0, s}, {16'b0, prv_sum[d]});
         chk($sformatf("L%0d_frz_cf", lat), {30'b0, co, of}, {30'b0, prv_cout[d], prv_ovf[d]});
      end
      prv_vld[d] = ov; prv_sum[d] = s; prv_cout[d] = co; prv_ovf[d] = of;
   endtask

   // Reference: signed and unsigned views of the same operation using integer arithmetic.
   task automatic record(input int i);
      int sres;
      int ures;
      if (sub) begin
         sres = $signed(a) - $signed(b);
         ures = int'(a) - int'(b);
         h_cout[i] = (a >= b);
      end else begin
         sres = $signed(a) + $signed(b) + int'(cin);
         ures = int'(a) + int'(b) + int'(cin);
         h_cout[i] = (ures > 65535);
      end
      h_vld[i] = in_valid;
      h_sum[i] = ures[15:0];
      h_ovf[i] = (sres > 32767) || (sres < -32768);
   endtask

   task automatic tick();
      held = !rst && !ce;
      if (rst) begin
         for (int i = 0; i < N; i++) h_vld[i] = 1'b0;
      end else if (ce) begin
         record(ecyc % N);
      end
      @(posedge clk);
      if (!rst && ce) ecyc++;
      #1;
      check_out(0, 1,  bus1.out_valid,  bus1.sum,  bus1.cout,  bus1.ovf);
      check_out(1, 4,  bus4.out_valid,  bus4.sum,  bus4.cout,  bus4.ovf);
      check_out(2, 16, bus16.out_valid, bus16.sum, bus16.cout, bus16.ovf);
   endtask

   task automatic drive(input logic v, input logic s, input logic c,
                        input logic [15:0] x, input logic [15:0] y);
      in_valid = v; sub = s; cin = c; a = x; b = y;
   endtask

   task automatic idle(input int n);
      drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      int issued;
      logic [15:0] ra, rb;
      for (int i = 0; i < N; i++) begin
         h_vld[i] = 1'b0; h_sum[i] = '0; h_cout[i] = 1'b0; h_ovf[i] = 1'b0;
      end
      for (int d = 0; d < 3; d++) begin
         prv_vld[d] = 1'b0; prv_sum[d] = '0; prv_cout[d] = 1'b0; prv_ovf[d] = 1'b0;
      end
      rst = 1'b1; ce = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
      tick(); tick();
      chk("rst_out1",  {bus1.out_valid, bus1.sum, bus1.cout, bus1.ovf}, 32'd0);
      chk("rst_out4",  {bus4.out_valid, bus4.sum, bus4.cout, bus4.ovf}, 32'd0);
      chk("rst_out16", {bus16.out_valid, bus16.sum, bus16.cout, bus16.ovf}, 32'd0);
      rst = 1'b0;
      idle(3);

      // Wrap-around, signed overflow and subtraction with borrow.
      drive(1'b1, 1'b0, 1'b0, 16'hFFFF, 16'h0001); tick();
      idle(18);
      drive(1'b1, 1'b0, 1'b0, 16'h7FFF, 16'h0001); tick();
      drive(1'b1, 1'b1, 1'b1, 16'h0005, 16'h0007); tick();
      drive(1'b1, 1'b1, 1'b0, 16'h8000, 16'h0001); tick();
      drive(1'b1, 1'b0, 1'b1, 16'hFFFF, 16'hFFFF); tick();
      idle(18);

      // Clock-enable hold with operations in flight; inputs toggle while held.
      drive(1'b1, 1'b0, 1'b1, 16'h1234, 16'h4321); tick();
      drive(1'b1, 1'b1, 1'b0, 16'h0100, 16'h0200); tick();
      ce = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
         tick();
      end
      ce = 1'b1;
      idle(18);

      // Reset with three operations in flight.
      drive(1'b1, 1'b0, 1'b0, 16'h00FF, 16'h0F0F); tick();
      drive(1'b1, 1'b1, 1'b0, 16'h8000, 16'h7FFF); tick();
      drive(1'b1, 1'b0, 1'b1, 16'hAAAA, 16'h5555); tick();
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0); tick();
      rst = 1'b0;
      idle(18);

      // Random stream with random bubbles and occasional corner operands.
      issued = 0;
      while (issued < 100) begin
         if ($urandom_range(3) != 0) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if ($urandom_range(7) == 0) ra = ($urandom_range(1) == 0) ? 16'hFFFF : 16'h7FFF;
            if ($urandom_range(7) == 0) rb = ($urandom_range(1) == 0) ? 16'h0001 : 16'h8000;
            drive(1'b1, 1'($urandom), 1'($urandom), ra, rb);
            issued++;
         end else begin
            drive(1'b0, 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
         end
         tick();
      end
      idle(18);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
